// File: rtl/tug_of_war_field_if.sv
// Player/playfield bus for the tug-of-war field: press inputs, lights, scores and
// result flags. dbg_state mirrors the internal FSM state (0=PLAY, 1=POINT, 2=GAMEOVER).
interface tug_of_war_field_if #(
    parameter int N  = 9,
    parameter int SW = 2
);
    logic          L;
    logic          R;
    logic [N-1:0]  lights;
    logic [SW-1:0] left_score;
    logic [SW-1:0] right_score;
    logic          point_left;
    logic          point_right;
    logic          left_won;
    logic          right_won;
    logic [1:0]    dbg_state;

    // Handshake: none. L/R are sampled every posedge; each high cycle is one press.
    modport master (
        output L, R,
        input  lights, left_score, right_score, point_left, point_right,
               left_won, right_won, dbg_state
    );

    modport slave (
        input  L, R,
        output lights, left_score, right_score, point_left, point_right,
               left_won, right_won, dbg_state
    );
endinterface

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: a single lit LED is pushed left/right by player presses;
// pushing it off an end scores a point, first to WIN_SCORE wins until reset.
module tug_of_war_field #(
    parameter int N           = 9,
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    tug_of_war_field_if.slave  bus
);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] POS_C   = PW'((N - 1) / 2);
    localparam logic [PW-1:0] POS_MAX = PW'(N - 1);
    localparam logic [N-1:0]  ONE     = N'(1);

    typedef enum logic [1:0] {
        S_PLAY     = 2'd0,
        S_POINT    = 2'd1,
        S_GAMEOVER = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pos;
    logic [HW-1:0] r_hold;
    logic [N-1:0]  r_lights;
    logic [SW-1:0] r_lscore;
    logic [SW-1:0] r_rscore;
    logic          r_pt_l;
    logic          r_pt_r;
    logic          r_lwon;
    logic          r_rwon;

    logic          w_push_left;
    logic          w_push_right;
    logic [PW-1:0] w_pos_up;
    logic [PW-1:0] w_pos_dn;

    assign w_push_left  = bus.L & ~bus.R;
    assign w_push_right = bus.R & ~bus.L;
    assign w_pos_up     = r_pos + PW'(1);
    assign w_pos_dn     = r_pos - PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_PLAY;
            r_pos    <= POS_C;
            r_hold   <= '0;
            r_lights <= ONE << POS_C;
            r_lscore <= '0;
            r_rscore <= '0;
            r_pt_l   <= 1'b0;
            r_pt_r   <= 1'b0;
            r_lwon   <= 1'b0;
            r_rwon   <= 1'b0;
        end else begin
            r_pt_l <= 1'b0;
            r_pt_r <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (w_push_left) begin
                        if (r_pos == POS_MAX) begin
                            // Scoring pulls the LED off the field; the winning point skips the hold.
                            r_lscore <= r_lscore + SW'(1);
                            r_pt_l   <= 1'b1;
                            r_lights <= '0;
                            if (r_lscore == SW'(WIN_SCORE - 1)) begin
                                r_state <= S_GAMEOVER;
                                r_lwon  <= 1'b1;
                            end else begin
                                r_state <= S_POINT;
                                r_hold  <= HW'(HOLD_CYCLES - 1);
                            end
                        end else begin
                            r_pos    <= w_pos_up;
                            r_lights <= ONE << w_pos_up;
                        end
                    end else if (w_push_right) begin
                        if (r_pos == '0) begin
                            r_rscore <= r_rscore + SW'(1);
                            r_pt_r   <= 1'b1;
                            r_lights <= '0;
                            if (r_rscore == SW'(WIN_SCORE - 1)) begin
                                r_state <= S_GAMEOVER;
                                r_rwon  <= 1'b1;
                            end else begin
                                r_state <= S_POINT;
                                r_hold  <= HW'(HOLD_CYCLES - 1);
                            end
                        end else begin
                            r_pos    <= w_pos_dn;
                            r_lights <= ONE << w_pos_dn;
                        end
                    end
                end
                S_POINT: begin
                    if (r_hold == '0) begin
                        r_state  <= S_PLAY;
                        r_pos    <= POS_C;
                        r_lights <= ONE << POS_C;
                    end else begin
                        r_hold <= r_hold - HW'(1);
                    end
                end
                default: begin
                    r_lights <= '0;
                end
            endcase
        end
    end

    assign bus.lights      = r_lights;
    assign bus.left_score  = r_lscore;
    assign bus.right_score = r_rscore;
    assign bus.point_left  = r_pt_l;
    assign bus.point_right = r_pt_r;
    assign bus.left_won    = r_lwon;
    assign bus.right_won   = r_rwon;
    assign bus.dbg_state   = r_state;
endmodule

// File: doc/tug_of_war_field.md
TUG_OF_WAR_FIELD -- requirements
Module: tug_of_war_field

Interface
REQ-001 Parameter N, default 9: number of playfield lights; SHALL be odd and >= 3; index N-1 is leftmost, index 0 is rightmost, center index C = (N-1)/2.
REQ-002 Parameter WIN_SCORE, default 3: points needed to win the game; SHALL be >= 1.
REQ-003 Parameter HOLD_CYCLES, default 4: cycles the field stays dark after a point; SHALL be >= 1.
REQ-004 Derived SW = $clog2(WIN_SCORE+1): score width.
REQ-005 clk  input  1  single system clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 L  input  1  left-player press; each cycle high counts as one press (upstream delivers one-cycle pulses).
REQ-008 R  input  1  right-player press; same semantics as L.
REQ-009 lights  output  N  playfield LEDs; one-hot in PLAY, all zero otherwise.
REQ-010 left_score  output  SW  left points won.
REQ-011 right_score  output  SW  right points won.
REQ-012 point_left  output  1  one-cycle pulse: left scored a point.
REQ-013 point_right  output  1  one-cycle pulse: right scored a point.
REQ-014 left_won  output  1  level: game over, left is the winner.
REQ-015 right_won  output  1  level: game over, right is the winner.

Function
REQ-016 State machine SHALL have three states: PLAY, POINT, GAMEOVER; all outputs SHALL be registered.
REQ-017 Internal position register pos (range 0..N-1); in PLAY, lights SHALL equal 1 << pos.
REQ-018 PLAY, L=1 and R=0, pos < N-1: pos SHALL increment at the sampling edge (lights move left, 1-cycle latency).
REQ-019 PLAY, R=1 and L=0, pos > 0: pos SHALL decrement at the sampling edge.
REQ-020 PLAY, L=R=1 or L=R=0: pos SHALL be unchanged.
REQ-021 PLAY, L=1, R=0, pos = N-1: left_score SHALL increment; point_left SHALL be high for exactly the next cycle; lights SHALL go all zero.
REQ-022 PLAY, R=1, L=0, pos = 0: mirror of REQ-021 using right_score and point_right.
REQ-023 After a point, if the new score equals WIN_SCORE, next state SHALL be GAMEOVER; otherwise POINT with hold counter loaded to HOLD_CYCLES-1.
REQ-024 POINT: L and R SHALL be ignored; the hold counter SHALL decrement each cycle; at the edge where the counter is 0, state SHALL become PLAY with pos = C, so lights are zero for exactly HOLD_CYCLES cycles.
REQ-025 GAMEOVER: lights SHALL be zero; left_won or right_won (the winner's) SHALL be held high; L and R SHALL be ignored; scores SHALL hold; exit only by reset.
REQ-026 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-027 At most one of point_left, point_right SHALL be high in any cycle; left_won and right_won SHALL be mutually exclusive.

Reset
REQ-028 Reset SHALL override all other inputs on the same edge, including mid-POINT and in GAMEOVER.
REQ-029 After a reset edge: state = PLAY, pos = C, lights = 1 << C, left_score = right_score = 0, point_left = point_right = 0, left_won = right_won = 0, hold counter = 0.

Verification (N=9, WIN_SCORE=3, HOLD_CYCLES=4)
REQ-030 Reset one cycle -> lights = 9'b000010000, both scores 0, all flags 0.
REQ-031 Four single-cycle L pulses -> lights 0x020, 0x040, 0x080, 0x100 on successive edges. A fifth L pulse -> point_left high one cycle, left_score = 1, lights = 0 for 4 cycles, then lights = 0x010.
REQ-032 From center: L=R=1 for 3 cycles -> lights stay 0x010. Then R pulses -> 0x008, 0x004, 0x002, 0x001. Next R -> point_right, right_score = 1.
REQ-033 L and R pulsed during POINT -> no position or score change; return to 0x010 exactly on schedule.
REQ-034 Left wins three points -> on the third, left_won = 1, lights = 0, left_score = 3, and no POINT phase. Further L/R for 10 cycles -> nothing changes. Reset -> REQ-029 values.
REQ-035 Reset asserted on the 2nd cycle of POINT with left_score = 2 -> next edge gives lights = 0x010 and both scores 0; point_left never re-asserts.
